// File: rtl/pic_n_pkg.sv
// rtl/pic_n_pkg.sv - shared constants and types for the pic_n interrupt controller
// Holds the register offsets, the CTRL/EOI field positions and the trigger-mode enum.
package pic_n_pkg;

  // Register offsets on the data_m bus
  localparam logic [2:0] OFF_CTRL = 3'd0;
  localparam logic [2:0] OFF_MASK = 3'd1;
  localparam logic [2:0] OFF_TRIG = 3'd2;
  localparam logic [2:0] OFF_IRR  = 3'd3;
  localparam logic [2:0] OFF_ISR  = 3'd4;
  localparam logic [2:0] OFF_EOI  = 3'd5;

  // CTRL fields
  localparam int CTRL_BASE_LSB = 8;
  localparam int CTRL_ROT_BIT  = 0;

  // EOI fields: bit 8 selects specific EOI, the channel index sits at the bottom
  localparam int EOI_SPEC_BIT = 8;
  localparam int EOI_IDX_LSB  = 0;

  // One TRIG bit per channel
  typedef enum logic {
    TRIG_EDGE  = 1'b0,
    TRIG_LEVEL = 1'b1
  } trig_mode_e;

endpackage

// File: rtl/pic_n_prio_resolver.sv
// rtl/pic_n_prio_resolver.sv - rotating find-first over request and in-service vectors
// Ports:
//   req   [NUM_IRQ]  candidate bits (IRR, or ISR when locating the top in-service bit)
//   blk   [NUM_IRQ]  blocking bits (ISR); a request wins only if strictly above all of them
//   ptr   [IDX_W]    lowest-priority channel; channel ptr+1 is the highest priority
//   valid            a request bit exists above every blocking bit
//   idx   [IDX_W]    channel number of the highest-priority request bit
module pic_n_prio_resolver #(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic [NUM_IRQ-1:0] req,
  input  logic [NUM_IRQ-1:0] blk,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  localparam logic [IDX_W:0]   NUM_IRQ_W = (IDX_W+1)'(NUM_IRQ);
  localparam logic [IDX_W-1:0] LAST_CH   = IDX_W'(NUM_IRQ-1);

  logic [IDX_W-1:0]     start;
  logic [2*NUM_IRQ-1:0] req_dbl;
  logic [2*NUM_IRQ-1:0] blk_dbl;
  logic [NUM_IRQ-1:0]   rot_req;
  logic [NUM_IRQ-1:0]   rot_blk;
  logic                 req_hit;
  logic                 blk_hit;
  logic [IDX_W-1:0]     req_pos;
  logic [IDX_W-1:0]     blk_pos;
  logic [IDX_W:0]       sum;

  // Highest-priority channel, wrapping past the last channel back to 0
  assign start = (ptr == LAST_CH) ? '0 : ptr + 1'b1;

  // Rotate so that bit 0 of rot_* is the highest-priority channel
  assign req_dbl = {req, req} >> start;
  assign blk_dbl = {blk, blk} >> start;
  assign rot_req = req_dbl[NUM_IRQ-1:0];
  assign rot_blk = blk_dbl[NUM_IRQ-1:0];

  always_comb begin
    req_hit = 1'b0;
    blk_hit = 1'b0;
    req_pos = '0;
    blk_pos = '0;
    for (int k = 0; k < NUM_IRQ; k++) begin
      if (!req_hit && rot_req[k]) begin
        req_hit = 1'b1;
        req_pos = IDX_W'(k);
      end
      if (!blk_hit && rot_blk[k]) begin
        blk_hit = 1'b1;
        blk_pos = IDX_W'(k);
      end
    end
  end

  // Equal rank means the same channel is already in service, so strictly-less only
  assign valid = req_hit && (!blk_hit || (req_pos < blk_pos));

  // Undo the rotation to get back a channel number
  assign sum = {1'b0, start} + {1'b0, req_pos};
  assign idx = (sum >= NUM_IRQ_W) ? IDX_W'(sum - NUM_IRQ_W) : sum[IDX_W-1:0];

endmodule

// File: rtl/pic_n.sv
// rtl/pic_n.sv - programmable interrupt controller with nesting and rotating priority
// Ports:
//   clk, reset               clock, asynchronous active-high reset
//   cs, data_m_access        register access strobe (both high = access cycle)
//   data_m_wr_en             1 = write, 0 = read
//   data_m_addr [3]          register offset (CTRL, MASK, TRIG, IRR, ISR, EOI)
//   data_m_data_in [16]      write data
//   data_m_data_out [16]     registered read data, valid alongside data_m_ack
//   data_m_ack               access acknowledge, one cycle after the access
//   intr_in [NUM_IRQ]        raw request lines
//   intr                     interrupt request to the CPU
//   irq [8]                  vector of the current winner (base + channel)
//   inta                     single-cycle acknowledge from the CPU
module pic_n
  import pic_n_pkg::*;
#(
  parameter int NUM_IRQ = 8,
  parameter int IDX_W   = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cs,
  input  logic               data_m_access,
  input  logic               data_m_wr_en,
  input  logic [2:0]         data_m_addr,
  input  logic [15:0]        data_m_data_in,
  output logic [15:0]        data_m_data_out,
  output logic               data_m_ack,
  input  logic [NUM_IRQ-1:0] intr_in,
  output logic               intr,
  output logic [7:0]         irq,
  input  logic               inta
);

  localparam logic [IDX_W:0]   NUM_IRQ_W = (IDX_W+1)'(NUM_IRQ);
  localparam logic [IDX_W-1:0] LAST_CH   = IDX_W'(NUM_IRQ-1);

  // Programmable state
  logic [7:0]         ctrl_base_q;
  logic               rotate_q;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] trig_q;

  // Request/service state
  logic [NUM_IRQ-1:0] irr_q;
  logic [NUM_IRQ-1:0] isr_q;
  logic [NUM_IRQ-1:0] intr_in_q;
  logic [IDX_W-1:0]   ptr_q;
  logic               win_vld_q;
  logic [IDX_W-1:0]   win_idx_q;

  logic [NUM_IRQ-1:0] irr_d;
  logic [NUM_IRQ-1:0] isr_d;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] inta_set;
  logic [NUM_IRQ-1:0] eoi_clr;
  logic [IDX_W-1:0]   eff_ptr;
  logic               res_vld;
  logic [IDX_W-1:0]   res_idx;
  logic               top_isr_vld;
  logic [IDX_W-1:0]   top_isr_idx;

  logic               bus_acc;
  logic               bus_wr;
  logic               bus_rd;
  logic [15:0]        rd_val;

  logic               eoi_wr;
  logic               eoi_spec;
  logic [IDX_W-1:0]   eoi_idx;
  logic               eoi_hit;
  logic [IDX_W-1:0]   eoi_ch;

  assign bus_acc = cs & data_m_access;
  assign bus_wr  = bus_acc & data_m_wr_en;
  assign bus_rd  = bus_acc & ~data_m_wr_en;

  // With rotation off, pinning the pointer to the last channel makes channel 0 highest
  assign eff_ptr = rotate_q ? ptr_q : LAST_CH;

  pic_n_prio_resolver #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_win (
    .req   (irr_q),
    .blk   (isr_q),
    .ptr   (eff_ptr),
    .valid (res_vld),
    .idx   (res_idx)
  );

  // Same search with nothing blocking locates the top in-service channel for non-specific EOI
  pic_n_prio_resolver #(.NUM_IRQ(NUM_IRQ), .IDX_W(IDX_W)) u_isr (
    .req   (isr_q),
    .blk   ('0),
    .ptr   (eff_ptr),
    .valid (top_isr_vld),
    .idx   (top_isr_idx)
  );

  assign intr = res_vld & ~inta;
  assign irq  = intr ? (ctrl_base_q + {{(8-IDX_W){1'b0}}, res_idx}) : 8'h00;

  // EOI decode; an out-of-range specific index or an empty ISR clears nothing
  assign eoi_wr   = bus_wr && (data_m_addr == OFF_EOI);
  assign eoi_spec = data_m_data_in[EOI_SPEC_BIT];
  assign eoi_idx  = data_m_data_in[EOI_IDX_LSB +: IDX_W];
  assign eoi_ch   = eoi_spec ? eoi_idx : top_isr_idx;
  assign eoi_hit  = eoi_wr && (eoi_spec ? ({1'b0, eoi_idx} < NUM_IRQ_W) : top_isr_vld);

  assign rise = intr_in & ~intr_in_q;

  always_comb begin
    inta_set = '0;
    eoi_clr  = '0;
    if (inta && win_vld_q) inta_set[win_idx_q] = 1'b1;
    if (eoi_hit) eoi_clr[eoi_ch] = 1'b1;
  end

  // Edge channels: a fresh unmasked edge overrides the delivery clear.
  // Level channels simply follow the unmasked line every cycle.
  always_comb begin
    irr_d = irr_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (trig_mode_e'(trig_q[i]) == TRIG_LEVEL) begin
        irr_d[i] = intr_in[i] & ~mask_q[i];
      end else begin
        irr_d[i] = (rise[i] & ~mask_q[i]) | (irr_q[i] & ~inta_set[i]);
      end
    end
  end

  // Delivery set wins over a coincident EOI on the same bit
  assign isr_d = (isr_q & ~eoi_clr) | inta_set;

  always_comb begin
    rd_val = '0;
    case (data_m_addr)
      OFF_CTRL: begin
        rd_val[CTRL_BASE_LSB +: 8] = ctrl_base_q;
        rd_val[CTRL_ROT_BIT]       = rotate_q;
      end
      OFF_MASK: rd_val[NUM_IRQ-1:0] = mask_q;
      OFF_TRIG: rd_val[NUM_IRQ-1:0] = trig_q;
      OFF_IRR:  rd_val[NUM_IRQ-1:0] = irr_q;
      OFF_ISR:  rd_val[NUM_IRQ-1:0] = isr_q;
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_base_q     <= '0;
      rotate_q        <= 1'b0;
      mask_q          <= '1;
      trig_q          <= '0;
      irr_q           <= '0;
      isr_q           <= '0;
      intr_in_q       <= '0;
      ptr_q           <= LAST_CH;
      win_vld_q       <= 1'b0;
      win_idx_q       <= '0;
      data_m_ack      <= 1'b0;
      data_m_data_out <= '0;
    end else begin
      intr_in_q       <= intr_in;
      irr_q           <= irr_d;
      isr_q           <= isr_d;
      data_m_ack      <= bus_acc;
      data_m_data_out <= bus_rd ? rd_val : 16'h0000;
      // The winner is frozen while inta is high so the acknowledge targets what was offered
      if (!inta) begin
        win_vld_q <= res_vld;
        win_idx_q <= res_idx;
      end
      if (eoi_hit && rotate_q) ptr_q <= eoi_ch;
      if (bus_wr) begin
        case (data_m_addr)
          OFF_CTRL: begin
            ctrl_base_q <= data_m_data_in[CTRL_BASE_LSB +: 8];
            rotate_q    <= data_m_data_in[CTRL_ROT_BIT];
          end
          OFF_MASK: mask_q <= data_m_data_in[NUM_IRQ-1:0];
          OFF_TRIG: trig_q <= data_m_data_in[NUM_IRQ-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pic_n.sv
// tb/tb_pic_n.sv - self-checking bench for pic_n: vector table, corner sequences, random vs model
module tb_pic_n;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        data_m_access;
  logic        data_m_wr_en;
  logic [2:0]  data_m_addr;
  logic [15:0] data_m_data_in;
  logic [15:0] data_m_data_out;
  logic        data_m_ack;
  logic [N-1:0] intr_in;
  logic        intr;
  logic [7:0]  irq;
  logic        inta;

  always #5 clk = ~clk;

  pic_n #(.NUM_IRQ(N)) dut (
    .clk             (clk),
    .reset           (reset),
    .cs              (cs),
    .data_m_access   (data_m_access),
    .data_m_wr_en    (data_m_wr_en),
    .data_m_addr     (data_m_addr),
    .data_m_data_in  (data_m_data_in),
    .data_m_data_out (data_m_data_out),
    .data_m_ack      (data_m_ack),
    .intr_in         (intr_in),
    .intr            (intr),
    .irq             (irq),
    .inta            (inta)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] iin = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic c, input logic a, input logic w, input logic [2:0] ad,
                        input logic [15:0] d, input logic ia);
    cs = c; data_m_access = a; data_m_wr_en = w; data_m_addr = ad;
    data_m_data_in = d; intr_in = iin; inta = ia;
  endtask

  task automatic idle();
    set_in(0, 0, 0, 3'd0, 16'h0, 0);
    @(negedge clk);
  endtask

  task automatic pulse_inta();
    set_in(0, 0, 0, 3'd0, 16'h0, 1);
    @(negedge clk);
    set_in(0, 0, 0, 3'd0, 16'h0, 0);
  endtask

  task automatic wr_reg(input logic [2:0] ad, input logic [15:0] d);
    set_in(1, 1, 1, ad, d, 0);
    @(negedge clk);
    set_in(0, 0, 0, 3'd0, 16'h0, 0);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] ad, input logic [15:0] exp);
    set_in(1, 1, 0, ad, 16'h0, 0);
    @(negedge clk);
    set_in(0, 0, 0, 3'd0, 16'h0, 0);
    #1;
    chk({name, "_ack"}, data_m_ack, 1);
    chk({name, "_data"}, data_m_data_out, exp);
  endtask

  task automatic chk_irq(input string name, input logic ei, input logic [7:0] eq);
    #1;
    chk({name, "_intr"}, intr, ei);
    chk({name, "_irq"}, irq, eq);
  endtask

  // ---------------- behavioural reference model ----------------
  bit [7:0]  m_mask, m_trig, m_irr, m_isr, m_prev, m_base;
  bit        m_rot, m_ack, m_wv;
  bit [15:0] m_dout;
  int        m_ptr, m_wi;

  task automatic model_reset();
    m_mask = 8'hFF; m_trig = 0; m_irr = 0; m_isr = 0; m_prev = 0; m_base = 0;
    m_rot = 0; m_ack = 0; m_wv = 0; m_dout = 0; m_ptr = N-1; m_wi = 0;
  endtask

  // 0 = highest priority: the channel right after the pointer
  function automatic int rank_of(int ch, int p);
    return (ch - p - 1 + 2*N) % N;
  endfunction

  function automatic int top_of(bit [7:0] v, int p);
    int best = -1;
    for (int ch = 0; ch < N; ch++)
      if (v[ch] && (best < 0 || rank_of(ch, p) < rank_of(best, p))) best = ch;
    return best;
  endfunction

  function automatic int eff_ptr();
    return m_rot ? m_ptr : N-1;
  endfunction

  function automatic int winner();
    int p = eff_ptr();
    int t = top_of(m_irr, p);
    int s = top_of(m_isr, p);
    if (t >= 0 && (s < 0 || rank_of(t, p) < rank_of(s, p))) return t;
    return -1;
  endfunction

  function automatic bit [15:0] reg_read(bit [2:0] ad);
    case (ad)
      3'd0: return {m_base, 7'd0, m_rot};
      3'd1: return {8'h00, m_mask};
      3'd2: return {8'h00, m_trig};
      3'd3: return {8'h00, m_irr};
      3'd4: return {8'h00, m_isr};
      default: return 16'h0;
    endcase
  endfunction

  task automatic model_step(input bit c, input bit a, input bit w, input bit [2:0] ad,
                            input bit [15:0] d, input bit ia);
    int p, wn, del, clr, k;
    bit [7:0] nirr, nisr;
    bit acc;
    p = eff_ptr(); wn = winner();
    acc = c && a;
    nirr = m_irr; nisr = m_isr;
    del = (ia && m_wv) ? m_wi : -1;
    for (int ch = 0; ch < N; ch++) begin
      if (m_trig[ch]) nirr[ch] = iin[ch] && !m_mask[ch];
      else begin
        if (ch == del) nirr[ch] = 0;
        if (iin[ch] && !m_prev[ch] && !m_mask[ch]) nirr[ch] = 1;
      end
    end
    clr = -1;
    if (acc && w && ad == 3'd5) begin
      if (d[8]) begin
        k = int'(d[2:0]);
        if (k < N) clr = k;
      end else clr = top_of(m_isr, p);
    end
    if (clr >= 0) nisr[clr] = 0;
    if (del >= 0) nisr[del] = 1;
    m_dout = (acc && !w) ? reg_read(ad) : 16'h0;
    m_ack = acc;
    if (clr >= 0 && m_rot) m_ptr = clr;
    if (!ia) begin
      m_wv = (wn >= 0);
      m_wi = (wn >= 0) ? wn : 0;
    end
    if (acc && w) begin
      case (ad)
        3'd0: begin m_base = d[15:8]; m_rot = d[0]; end
        3'd1: m_mask = d[7:0];
        3'd2: m_trig = d[7:0];
        default: ;
      endcase
    end
    m_irr = nirr; m_isr = nisr; m_prev = iin;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    iin = 8'h00;
    set_in(0, 0, 0, 3'd0, 16'h0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit        cs, acc, wr;
    bit [2:0]  addr;
    bit [15:0] din;
    bit [7:0]  iin;
    bit        inta;
    bit        e_intr;
    bit [7:0]  e_irq;
    bit        e_ack;
    bit [15:0] e_dout;
  } vec_t;

  function automatic vec_t mk(bit c, bit a, bit w, bit [2:0] ad, bit [15:0] d, bit [7:0] li,
                              bit ia, bit ei, bit [7:0] eq, bit ek, bit [15:0] ed);
    vec_t v;
    v.cs = c; v.acc = a; v.wr = w; v.addr = ad; v.din = d; v.iin = li; v.inta = ia;
    v.e_intr = ei; v.e_irq = eq; v.e_ack = ek; v.e_dout = ed;
    return v;
  endfunction

  vec_t tbl[21];
  logic [15:0] rst_exp [8];

  initial begin
    // Basic delivery, nesting, non-specific and specific EOI
    tbl[0]  = mk(1,1,0,3'd1,16'h0000,8'h00,0, 0,8'h00,0,16'h0000);
    tbl[1]  = mk(1,1,0,3'd2,16'h0000,8'h00,0, 0,8'h00,1,16'h00FF);
    tbl[2]  = mk(1,1,0,3'd0,16'h0000,8'h00,0, 0,8'h00,1,16'h0000);
    tbl[3]  = mk(1,1,1,3'd1,16'h0000,8'h00,0, 0,8'h00,1,16'h0000);
    tbl[4]  = mk(1,1,1,3'd0,16'h2000,8'h00,0, 0,8'h00,1,16'h0000);
    tbl[5]  = mk(0,0,0,3'd0,16'h0000,8'h08,0, 0,8'h00,1,16'h0000);
    tbl[6]  = mk(0,0,0,3'd0,16'h0000,8'h08,0, 1,8'h23,0,16'h0000);
    tbl[7]  = mk(0,0,0,3'd0,16'h0000,8'h08,1, 0,8'h00,0,16'h0000);
    tbl[8]  = mk(1,1,0,3'd4,16'h0000,8'h08,0, 0,8'h00,0,16'h0000);
    tbl[9]  = mk(1,1,0,3'd3,16'h0000,8'h08,0, 0,8'h00,1,16'h0008);
    tbl[10] = mk(0,0,0,3'd0,16'h0000,8'h28,0, 0,8'h00,1,16'h0000);
    tbl[11] = mk(0,0,0,3'd0,16'h0000,8'h28,0, 0,8'h00,0,16'h0000);
    tbl[12] = mk(0,0,0,3'd0,16'h0000,8'h2A,0, 0,8'h00,0,16'h0000);
    tbl[13] = mk(0,0,0,3'd0,16'h0000,8'h2A,0, 1,8'h21,0,16'h0000);
    tbl[14] = mk(0,0,0,3'd0,16'h0000,8'h2A,1, 0,8'h00,0,16'h0000);
    tbl[15] = mk(1,1,0,3'd4,16'h0000,8'h2A,0, 0,8'h00,0,16'h0000);
    tbl[16] = mk(0,0,0,3'd0,16'h0000,8'h2A,0, 0,8'h00,1,16'h000A);
    tbl[17] = mk(1,1,1,3'd5,16'h0000,8'h2A,0, 0,8'h00,0,16'h0000);
    tbl[18] = mk(0,0,0,3'd0,16'h0000,8'h2A,0, 0,8'h00,1,16'h0000);
    tbl[19] = mk(1,1,1,3'd5,16'h0103,8'h2A,0, 0,8'h00,0,16'h0000);
    tbl[20] = mk(0,0,0,3'd0,16'h0000,8'h2A,0, 1,8'h25,1,16'h0000);

    rst_exp = '{16'h0000, 16'h00FF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

    // Outputs while reset is held
    reset = 1'b1;
    set_in(0, 0, 0, 3'd0, 16'h0, 0);
    @(negedge clk);
    #1;
    chk("rst_intr", intr, 0);
    chk("rst_irq", irq, 0);
    chk("rst_ack", data_m_ack, 0);
    chk("rst_dout", data_m_data_out, 0);

    do_reset();
    for (int r = 0; r < 21; r++) begin
      iin = tbl[r].iin;
      set_in(tbl[r].cs, tbl[r].acc, tbl[r].wr, tbl[r].addr, tbl[r].din, tbl[r].inta);
      #1;
      chk($sformatf("tbl%0d_intr", r), intr, tbl[r].e_intr);
      chk($sformatf("tbl%0d_irq", r), irq, tbl[r].e_irq);
      chk($sformatf("tbl%0d_ack", r), data_m_ack, tbl[r].e_ack);
      chk($sformatf("tbl%0d_dout", r), data_m_data_out, tbl[r].e_dout);
      @(negedge clk);
    end

    // Rotation: service ch0, non-specific EOI moves pointer to 0
    do_reset();
    wr_reg(3'd1, 16'h0000);
    wr_reg(3'd0, 16'h3001);
    iin = 8'h05; idle();
    chk_irq("rot_first", 1, 8'h30);
    idle();
    pulse_inta();
    chk_irq("rot_blocked", 0, 8'h00);
    iin = 8'h00; idle();
    wr_reg(3'd5, 16'h0000);
    chk_irq("rot_after_eoi", 1, 8'h32);
    iin = 8'h01; idle();
    chk_irq("rot_ptr0", 1, 8'h32);

    // Level channel held through inta and EOI
    do_reset();
    wr_reg(3'd1, 16'h0000);
    wr_reg(3'd2, 16'h0010);
    wr_reg(3'd0, 16'h4000);
    iin = 8'h10; idle();
    chk_irq("lvl_req", 1, 8'h44);
    idle();
    pulse_inta();
    chk_irq("lvl_insvc", 0, 8'h00);
    wr_reg(3'd5, 16'h0104);
    chk_irq("lvl_after_eoi", 1, 8'h44);
    rd_chk("lvl_irr_set", 3'd3, 16'h0010);
    rd_chk("lvl_isr_clr", 3'd4, 16'h0000);
    iin = 8'h00; idle();
    rd_chk("lvl_irr_drop", 3'd3, 16'h0000);
    chk_irq("lvl_drop", 0, 8'h00);

    // Edge on the delivered channel coincident with inta
    do_reset();
    wr_reg(3'd1, 16'h0000);
    iin = 8'h04; idle(); idle();
    iin = 8'h00; idle();
    iin = 8'h04; pulse_inta();
    chk_irq("coinc_nointr", 0, 8'h00);
    rd_chk("coinc_irr", 3'd3, 16'h0004);
    rd_chk("coinc_isr", 3'd4, 16'h0004);

    // inta with no registered winner changes nothing
    do_reset();
    wr_reg(3'd1, 16'h0000);
    pulse_inta();
    rd_chk("noint_isr", 3'd4, 16'h0000);

    // Reset in the middle of an access
    do_reset();
    wr_reg(3'd1, 16'h0000);
    wr_reg(3'd0, 16'h1201);
    wr_reg(3'd2, 16'h00F0);
    iin = 8'h01; idle(); idle();
    pulse_inta();
    rd_chk("pre_rst_isr", 3'd4, 16'h0001);
    set_in(1, 1, 0, 3'd4, 16'h0, 0);
    #2 reset = 1'b1;
    #1 chk("rst_mid_ack", data_m_ack, 0);
    @(posedge clk);
    #1 chk("rst_mid_ack_edge", data_m_ack, 0);
    @(negedge clk);
    reset = 1'b0;
    iin = 8'h00;
    set_in(0, 0, 0, 3'd0, 16'h0, 0);
    @(negedge clk);
    #1 chk("rst_no_ack_after", data_m_ack, 0);
    chk_irq("rst_out", 0, 8'h00);
    for (int a = 0; a < 8; a++) rd_chk($sformatf("rst_reg%0d", a), 3'(a), rst_exp[a]);

    // Randomized traffic against the reference model
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      int w_exp;
      bit rc, ra, rw, ri;
      bit [2:0] rad;
      bit [15:0] rdat;
      if ($urandom_range(0, 3) == 0) begin
        int b = $urandom_range(0, N-1);
        iin[b] = ~iin[b];
      end
      rc   = ($urandom_range(0, 2) != 0);
      ra   = $urandom_range(0, 1) == 1;
      rw   = $urandom_range(0, 1) == 1;
      rad  = 3'($urandom_range(0, 7));
      rdat = 16'($urandom);
      ri   = ($urandom_range(0, 5) == 0);
      set_in(rc, ra, rw, rad, rdat, ri);
      #1;
      w_exp = winner();
      chk("rnd_intr", intr, (w_exp >= 0 && !ri) ? 1 : 0);
      chk("rnd_irq", irq, (w_exp >= 0 && !ri) ? 32'((m_base + w_exp) & 255) : 0);
      chk("rnd_ack", data_m_ack, m_ack);
      chk("rnd_dout", data_m_data_out, m_dout);
      model_step(rc, ra, rw, rad, rdat, ri);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pic_n.md
PIC_N -- requirements
Module: pic_n

Interface
REQ-001 Parameter NUM_IRQ, default 8, number of request channels; legal values 2..16.
REQ-002 Parameter IDX_W, default $clog2(NUM_IRQ), width of a channel index.
REQ-003 clk  input  1  clock; all state is updated on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cs  input  1  block select.
REQ-006 data_m_access  input  1  bus access strobe.
REQ-007 data_m_wr_en  input  1  1 = write, 0 = read.
REQ-008 data_m_addr  input  3  register offset.
REQ-009 data_m_data_in  input  16  write data.
REQ-010 data_m_data_out  output  16  read data; registered, 0 when not reading.
REQ-011 data_m_ack  output  1  access acknowledge.
REQ-012 intr_in  input  NUM_IRQ  raw interrupt request lines.
REQ-013 intr  output  1  interrupt request to the CPU.
REQ-014 irq  output  8  vector of the current winning channel; 0 when intr=0.
REQ-015 inta  input  1  single-cycle interrupt acknowledge from the CPU.

Function
REQ-016 Register map (16-bit, bits above NUM_IRQ-1 read 0):
- 0 CTRL: [15:8] vector base, [0] rotate enable.
- 1 MASK.
- 2 TRIG: 1 = level, 0 = edge.
- 3 IRR (RO).
- 4 ISR (RO).
- 5 EOI (WO): [8] = 1 specific, [IDX_W-1:0] index; [8] = 0 non-specific.
REQ-017 data_m_ack SHALL equal cs&data_m_access delayed by exactly one cycle.
REQ-018 Read data SHALL be registered in the access cycle and be valid with ack; it SHALL be 0 otherwise.
REQ-019 Writes SHALL take effect at the end of the access cycle; writes to RO or unmapped offsets SHALL be ignored, and reads of EOI or unmapped offsets SHALL return 0.
REQ-020 Edge channel: a rising intr_in (vs. the previous-cycle sample) with its mask bit 0 SHALL set IRR; masked edges SHALL be discarded.
REQ-021 Level channel: IRR SHALL be set each cycle intr_in=1 and mask=0, and cleared when intr_in=0 or mask=1.
REQ-022 Priority: with rotate=0, channel 0 is highest; with rotate=1, the channel after the lowest-priority pointer is highest.
REQ-023 The lowest-priority pointer resets to NUM_IRQ-1; on any EOI with rotate=1, the pointer SHALL become the channel cleared.
REQ-024 The winner SHALL be the highest-priority IRR bit strictly above the highest-priority ISR bit (fully nested); intr=1 iff a winner exists and inta=0.
REQ-025 irq SHALL equal vector base + winner index, with 8-bit wrap-around.
REQ-026 The winner index SHALL be registered every cycle in which inta=0; on inta, the registered channel SHALL set ISR and clear IRR.
REQ-027 inta received with no registered winner SHALL change no state.
REQ-028 An edge on the delivered channel in the same cycle as inta SHALL leave IRR set (set beats clear); edges on other channels during inta SHALL be captured.
REQ-029 Non-specific EOI SHALL clear the highest-priority ISR bit, and SHALL be a no-op when ISR=0.
REQ-030 Specific EOI SHALL clear ISR[index]; an index >= NUM_IRQ SHALL be ignored.
REQ-031 If EOI and inta target the same ISR bit in the same cycle, the set SHALL win.

Reset
REQ-032 Reset values: MASK all ones, TRIG 0, CTRL 0, IRR 0, ISR 0, pointer NUM_IRQ-1, registered winner invalid, intr_in sample 0.
REQ-033 Reset outputs: intr 0, irq 0, data_m_data_out 0, data_m_ack 0.
REQ-034 Reset asserted mid-access or mid-acknowledge SHALL abandon the operation and produce no ack after release.

Structure
REQ-035 Package pic_n_pkg SHALL hold the register-offset constants, the EOI field positions and the trigger-mode enum.
REQ-036 Sub-module pic_n_prio_resolver SHALL perform the combinational rotate-and-find-first over IRR/ISR, producing a valid flag and an index.

Verification
REQ-037 Write MASK=0 and CTRL=0x2000, edge on ch3 -> intr=1, irq=0x23; inta -> ISR=0x0008, IRR=0, intr=0.
REQ-038 With ch3 in service, edge on ch5 -> intr stays 0; edge on ch1 -> intr=1, irq=base+1 (nesting).
REQ-039 rotate=1 with ch0 and ch2 pending, service ch0, non-specific EOI -> next irq=base+2, pointer=0.
REQ-040 TRIG[4]=1 with intr_in[4] held high through inta and EOI -> IRR[4] is set again the cycle after EOI; dropping the line clears IRR[4].
REQ-041 Edge on the delivered channel coincident with inta -> ISR and IRR bits both 1 on the next cycle.
REQ-042 Reset asserted during an access cycle -> no ack; all registers read back their reset values.
